// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler
//   Buffers resolved-branch records coming out of EX and feeds them, one per
//   non-stalled cycle, into the branch predictor's table-update port.
//   Mispredicts are detected when a record is accepted. The block then issues
//   a registered one-cycle flush/redirect and discards wrong-path results
//   for SQUASH_CYCLES cycles.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   stall           pipeline stall, blocks popping
//   res_*           resolved-branch record from EX (valid/ready handshake)
//   upd_*           head record presented to the predictor (upd_valid = pop)
//   flush/flush_pc  one-cycle redirect pulse and target
//   count/full/empty queue occupancy
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | queue empty, accepting records
// DRAIN | queue holds records, popping one per non-stalled cycle
// FLUSH | redirect issued; incoming results dropped, queue keeps draining
module bp_update_scheduler #(
  parameter int DEPTH         = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic                       res_branch,
  input  logic [31:0]                res_pc,
  input  logic [31:0]                res_target,
  input  logic [31:0]                res_predict_pc,
  input  logic                       res_predict,
  input  logic                       res_actual,
  output logic                       upd_valid,
  output logic [31:0]                upd_branch_pc,
  output logic [31:0]                upd_pc,
  output logic [31:0]                upd_predict_pc,
  output logic                       upd_predict,
  output logic                       upd_actual,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(SQUASH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic [SW-1:0]   sq_cnt, sq_cnt_nxt;

  logic [31:0]     mem_pc         [DEPTH];
  logic [31:0]     mem_target     [DEPTH];
  logic [31:0]     mem_predict_pc [DEPTH];
  logic            mem_predict    [DEPTH];
  logic            mem_actual     [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic            mp;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ready deliberately ignores a same-cycle pop so a full queue never
  // accepts, keeping the ready path independent of stall.
  assign res_ready = !full && (state != FLUSH);
  assign accept    = res_valid && res_ready;
  assign mp        = accept && (res_actual != res_predict) &&
                     (res_predict_pc != res_target);
  assign push      = accept && res_branch;

  assign upd_valid = !empty && !stall;
  assign pop       = upd_valid;

  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    upd_branch_pc  = '0;
    upd_pc         = '0;
    upd_predict_pc = '0;
    upd_predict    = 1'b0;
    upd_actual     = 1'b0;
    if (!empty) begin
      upd_branch_pc  = mem_pc[rd_ptr];
      upd_pc         = mem_target[rd_ptr];
      upd_predict_pc = mem_predict_pc[rd_ptr];
      upd_predict    = mem_predict[rd_ptr];
      upd_actual     = mem_actual[rd_ptr];
    end
  end

  // The squash counter is loaded with SQUASH_CYCLES-1 so that FLUSH,
  // including its exit cycle, lasts exactly SQUASH_CYCLES cycles.
  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    case (state)
      IDLE: begin
        if (mp) begin
          state_nxt  = FLUSH;
          sq_cnt_nxt = SW'(SQUASH_CYCLES - 1);
        end else if (push) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mp) begin
          state_nxt  = FLUSH;
          sq_cnt_nxt = SW'(SQUASH_CYCLES - 1);
        end else if (count_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (sq_cnt == '0) begin
          state_nxt = (count_nxt != '0) ? DRAIN : IDLE;
        end else begin
          sq_cnt_nxt = sq_cnt - SW'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        sq_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sq_cnt   <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      sq_cnt <= sq_cnt_nxt;
      flush  <= mp;
      if (mp) begin
        flush_pc <= res_target;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]         <= res_pc;
      mem_target[wr_ptr]     <= res_target;
      mem_predict_pc[wr_ptr] <= res_predict_pc;
      mem_predict[wr_ptr]    <= res_predict;
      mem_actual[wr_ptr]     <= res_actual;
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler
//   Directed scenarios followed by random traffic, every cycle compared
//   against a queue-based reference model of the scheduler.
module tb_bp_update_scheduler;

  localparam int DEPTH         = 4;
  localparam int SQUASH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        res_valid;
  logic        res_ready;
  logic        res_branch;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic [31:0] res_predict_pc;
  logic        res_predict;
  logic        res_actual;
  logic        upd_valid;
  logic [31:0] upd_branch_pc;
  logic [31:0] upd_pc;
  logic [31:0] upd_predict_pc;
  logic        upd_predict;
  logic        upd_actual;
  logic        flush;
  logic [31:0] flush_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  bp_update_scheduler #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQUASH_CYCLES)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .res_valid(res_valid), .res_ready(res_ready), .res_branch(res_branch),
    .res_pc(res_pc), .res_target(res_target), .res_predict_pc(res_predict_pc),
    .res_predict(res_predict), .res_actual(res_actual),
    .upd_valid(upd_valid), .upd_branch_pc(upd_branch_pc), .upd_pc(upd_pc),
    .upd_predict_pc(upd_predict_pc), .upd_predict(upd_predict),
    .upd_actual(upd_actual), .flush(flush), .flush_pc(flush_pc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ppc;
    logic        pr;
    logic        ac;
  } rec_t;

  rec_t        mq[$];
  int          m_squash   = 0;
  logic        m_flush    = 1'b0;
  logic [31:0] m_flush_pc = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [31:0] ppc,
                       input logic pr, input logic ac, input logic st);
    res_valid      = v;
    res_branch     = br;
    res_pc         = pc;
    res_target     = tgt;
    res_predict_pc = ppc;
    res_predict    = pr;
    res_actual     = ac;
    stall          = st;
  endtask

  // Called just after a falling edge with inputs applied: checks outputs,
  // then advances the model across the rising edge.
  task automatic step();
    rec_t h;
    logic e_ready, e_uv, acc, mp;
    #1;
    e_ready = (mq.size() < DEPTH) && (m_squash == 0);
    e_uv    = (mq.size() != 0) && !stall;
    h       = (mq.size() != 0) ? mq[0] : '0;
    check("res_ready",      32'(res_ready),   32'(e_ready));
    check("upd_valid",      32'(upd_valid),   32'(e_uv));
    check("upd_branch_pc",  upd_branch_pc,    h.pc);
    check("upd_pc",         upd_pc,           h.tgt);
    check("upd_predict_pc", upd_predict_pc,   h.ppc);
    check("upd_predict",    32'(upd_predict), 32'(h.pr));
    check("upd_actual",     32'(upd_actual),  32'(h.ac));
    check("count",          32'(count),       32'(mq.size()));
    check("full",           32'(full),        32'(mq.size() == DEPTH));
    check("empty",          32'(empty),       32'(mq.size() == 0));
    check("flush",          32'(flush),       32'(m_flush));
    check("flush_pc",       flush_pc,         m_flush_pc);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_squash   = 0;
      m_flush    = 1'b0;
      m_flush_pc = '0;
    end else begin
      acc = res_valid && e_ready;
      mp  = acc && (res_actual != res_predict) && (res_predict_pc != res_target);
      if (e_uv) void'(mq.pop_front());
      if (acc && res_branch)
        mq.push_back('{pc: res_pc, tgt: res_target, ppc: res_predict_pc,
                       pr: res_predict, ac: res_actual});
      if (mp) begin
        m_squash   = SQUASH_CYCLES;
        m_flush_pc = res_target;
      end else if (m_squash > 0) begin
        m_squash--;
      end
      m_flush = mp;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, st);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Three in-order conditional records, no mispredict.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i),
            32'h104 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(4, 1'b0);

    // Fill under stall, fifth offer refused, then drain.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h180 + 32'(4 * i), 32'h184 + 32'(4 * i),
            32'h184 + 32'(4 * i), 1'b1, 1'b1, 1'b1);
      step();
    end
    idle(6, 1'b0);

    // Mispredict, wrong-path offers during the squash window.
    drive(1'b1, 1'b1, 32'h200, 32'h240, 32'h204, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h900 + 32'(4 * i), 32'h904, 32'h904, 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(3, 1'b0);

    // Jumps: correct one, then a mispredicted one.
    drive(1'b1, 1'b0, 32'h2f0, 32'h300, 32'h300, 1'b1, 1'b1, 1'b0);
    step();
    idle(1, 1'b0);
    drive(1'b1, 1'b0, 32'h2f0, 32'h300, 32'h104, 1'b0, 1'b1, 1'b0);
    step();
    idle(3, 1'b0);

    // Reset during the first flush cycle.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i),
            32'h404 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 1'b1, 32'h408, 32'h500, 32'h40c, 1'b1, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    idle(1, 1'b0);
    rst = 1'b0;
    idle(2, 1'b0);

    // Back-to-back accept and pop, pointers wrap.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, 32'h600 + 32'(4 * i), 32'h604 + 32'(4 * i),
            32'h604 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
      step();
    end
    idle(3, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, tgt, ppc;
      pc  = $urandom & 32'hffff_fffc;
      tgt = $urandom & 32'hffff_fffc;
      ppc = ($urandom_range(0, 1) == 0) ? tgt : ($urandom & 32'hffff_fffc);
      rst = ($urandom_range(0, 149) == 0);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), pc, tgt, ppc,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3));
      step();
    end
    rst = 1'b0;
    idle(6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
